// File: rtl/core_irq_pkg.sv
// Shared constants and address decode for the core-side interrupt controller.
package core_irq_pkg;

  localparam int unsigned IrqSoftBit  = 3;
  localparam int unsigned IrqTimerBit = 7;
  localparam int unsigned IrqExtBit   = 11;
  localparam int unsigned IrqFastBase = 16;

  localparam logic [3:0] RegPending = 4'h0;
  localparam logic [3:0] RegEnable  = 4'h4;
  localparam logic [3:0] RegMode    = 4'h8;
  localparam logic [3:0] RegSwirq   = 4'hC;

  typedef enum logic [2:0] {
    RegSelPending,
    RegSelEnable,
    RegSelMode,
    RegSelSwirq,
    RegSelNone
  } reg_sel_e;

  // Byte-lane bits of the offset are don't-care.
  function automatic reg_sel_e decode_addr(input logic [3:0] addr);
    reg_sel_e sel;
    case ({addr[3:2], 2'b00})
      RegPending: sel = RegSelPending;
      RegEnable:  sel = RegSelEnable;
      RegMode:    sel = RegSelMode;
      RegSwirq:   sel = RegSelSwirq;
      default:    sel = RegSelNone;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/core_irq_sync.sv
// Multi-stage flop synchroniser; Stages=0 passes the input straight through.
module core_irq_sync #(
  parameter int unsigned Width  = 1,
  parameter int unsigned Stages = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  if (Stages == 0) begin : g_bypass
    logic unused_clk;
    assign unused_clk = clk_i ^ rst_ni;
    assign q_o = d_i;
  end else begin : g_sync
    logic [Stages-1:0][Width-1:0] stage_q;

    // NOTE: non-blocking assignments make every stage take its neighbour's pre-edge value.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        stage_q <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int k = 1; k < Stages; k++) stage_q[k] <= stage_q[k-1];
      end
    end

    assign q_o = stage_q[Stages-1];
  end

endmodule

// File: rtl/core_irq_ctrl.sv
// Interrupt controller feeding the cv32e40p irq_i vector: fast-line pending/enable/mode
// logic, software IRQ and a small register port.
module core_irq_ctrl
  import core_irq_pkg::*;
#(
  parameter int unsigned        NumIrqs     = 16,
  parameter int unsigned        SyncStages  = 2,
  parameter logic [NumIrqs-1:0] ResetEnable = '0,
  parameter logic [NumIrqs-1:0] ResetMode   = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NumIrqs-1:0] irqs_i,
  input  logic               timer0_irq_i,
  input  logic               irq_ack_i,
  input  logic [4:0]         irq_id_i,
  output logic [31:0]        irq_o,
  input  logic               reg_req_i,
  input  logic               reg_we_i,
  input  logic [3:0]         reg_addr_i,
  input  logic [31:0]        reg_wdata_i,
  output logic [31:0]        reg_rdata_o,
  output logic               reg_rvalid_o
);

  logic [NumIrqs-1:0] s, s_d, edge_det;
  logic [NumIrqs-1:0] pending_q, pending_d, enable_q, mode_q, mode_d, mode_chg;
  logic [NumIrqs-1:0] ack_clr, w1c_clr;
  logic               swirq_q;
  logic               wr;
  reg_sel_e           sel;
  logic [31:0]        rdata_d;
  logic               unused_bits;

  core_irq_sync #(
    .Width (NumIrqs),
    .Stages(SyncStages)
  ) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (irqs_i),
    .q_o   (s)
  );

  assign sel      = decode_addr(reg_addr_i);
  assign wr       = reg_req_i & reg_we_i;
  assign edge_det = s & ~s_d;
  assign w1c_clr  = (wr && sel == RegSelPending) ? reg_wdata_i[NumIrqs-1:0] : '0;
  assign mode_d   = (wr && sel == RegSelMode) ? reg_wdata_i[NumIrqs-1:0] : mode_q;
  assign mode_chg = mode_d ^ mode_q;

  assign unused_bits = ^{reg_addr_i[1:0], reg_wdata_i[31:NumIrqs]};

  // Only IDs that map onto a fast line can clear it; 3/7/11 and others fall through.
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NumIrqs; i++) begin
      ack_clr[i] = irq_ack_i && (irq_id_i == 5'(IrqFastBase + i));
    end
  end

  // A mode switch wipes the bit; edge bits let a new edge beat a same-cycle clear.
  always_comb begin
    // NOTE: a default before the loop keeps every path assigned, so no latch is inferred.
    pending_d = '0;
    for (int i = 0; i < NumIrqs; i++) begin
      if (mode_chg[i]) begin
        pending_d[i] = 1'b0;
      end else if (mode_q[i]) begin
        pending_d[i] = edge_det[i] | (pending_q[i] & ~(ack_clr[i] | w1c_clr[i]));
      end else begin
        pending_d[i] = s[i];
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    unique case (sel)
      RegSelPending: rdata_d[NumIrqs-1:0] = pending_q;
      RegSelEnable:  rdata_d[NumIrqs-1:0] = enable_q;
      RegSelMode:    rdata_d[NumIrqs-1:0] = mode_q;
      RegSelSwirq:   rdata_d[0]           = swirq_q;
      default:       rdata_d              = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s_d          <= '0;
      pending_q    <= '0;
      enable_q     <= ResetEnable;
      mode_q       <= ResetMode;
      swirq_q      <= 1'b0;
      reg_rvalid_o <= 1'b0;
      reg_rdata_o  <= '0;
    end else begin
      s_d          <= s;
      pending_q    <= pending_d;
      mode_q       <= mode_d;
      reg_rvalid_o <= reg_req_i;
      if (reg_req_i) reg_rdata_o <= rdata_d;
      if (wr && sel == RegSelEnable) enable_q <= reg_wdata_i[NumIrqs-1:0];
      if (wr && sel == RegSelSwirq) swirq_q <= reg_wdata_i[0];
    end
  end

  always_comb begin
    irq_o                              = '0;
    irq_o[IrqSoftBit]                  = swirq_q;
    irq_o[IrqTimerBit]                 = timer0_irq_i;
    irq_o[IrqExtBit]                   = 1'b0;
    irq_o[IrqFastBase +: NumIrqs]      = pending_q & enable_q;
  end

endmodule

// File: tb/tb_core_irq_ctrl.sv
// Self-checking bench for core_irq_ctrl: directed scenarios plus random traffic, all
// compared each cycle against a behavioural model of the interrupt rules.
module tb_core_irq_ctrl;

  localparam int N    = 16;
  localparam int SYNC = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [N-1:0] irqs_i = '0;
  logic        timer0_irq_i = 1'b0;
  logic        irq_ack_i = 1'b0;
  logic [4:0]  irq_id_i = '0;
  logic [31:0] irq_o;
  logic        reg_req_i = 1'b0;
  logic        reg_we_i = 1'b0;
  logic [3:0]  reg_addr_i = '0;
  logic [31:0] reg_wdata_i = '0;
  logic [31:0] reg_rdata_o;
  logic        reg_rvalid_o;

  core_irq_ctrl dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .irqs_i      (irqs_i),
    .timer0_irq_i(timer0_irq_i),
    .irq_ack_i   (irq_ack_i),
    .irq_id_i    (irq_id_i),
    .irq_o       (irq_o),
    .reg_req_i   (reg_req_i),
    .reg_we_i    (reg_we_i),
    .reg_addr_i  (reg_addr_i),
    .reg_wdata_i (reg_wdata_i),
    .reg_rdata_o (reg_rdata_o),
    .reg_rvalid_o(reg_rvalid_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference model: input history per clock plus architectural register contents.
  logic [N-1:0] hist[$];
  logic [N-1:0] m_pend, m_en, m_mode;
  logic         m_swirq, m_rvalid;
  logic [31:0]  m_rdata;

  function automatic void model_reset();
    hist.delete();
    for (int k = 0; k <= SYNC; k++) hist.push_back('0);
    m_pend = '0; m_en = '0; m_mode = '0; m_swirq = 1'b0;
    m_rvalid = 1'b0; m_rdata = '0;
  endfunction

  // Evaluated once per rising edge with the inputs that were stable before it.
  function automatic void model_step();
    logic [N-1:0] s, s_d, ack_m, w1c, new_mode;
    logic [31:0]  rd;
    bit           wr;
    if (!rst_ni) begin
      model_reset();
      return;
    end
    s   = hist[hist.size()-SYNC];      // input as it was SYNC edges ago
    s_d = hist[hist.size()-SYNC-1];    // one edge older still
    ack_m = '0;
    if (irq_ack_i && int'(irq_id_i) >= 16 && int'(irq_id_i) < 16 + N) ack_m[int'(irq_id_i) - 16] = 1'b1;
    wr  = reg_req_i && reg_we_i;
    w1c = (wr && reg_addr_i[3:2] == 2'd0) ? reg_wdata_i[N-1:0] : '0;
    new_mode = (wr && reg_addr_i[3:2] == 2'd2) ? reg_wdata_i[N-1:0] : m_mode;
    case (reg_addr_i[3:2])
      2'd0:    rd = 32'(m_pend);
      2'd1:    rd = 32'(m_en);
      2'd2:    rd = 32'(m_mode);
      default: rd = 32'(m_swirq);
    endcase
    for (int i = 0; i < N; i++) begin
      if (new_mode[i] != m_mode[i]) m_pend[i] = 1'b0;
      else if (m_mode[i]) m_pend[i] = (s[i] && !s_d[i]) || (m_pend[i] && !ack_m[i] && !w1c[i]);
      else m_pend[i] = s[i];
    end
    m_mode = new_mode;
    if (wr && reg_addr_i[3:2] == 2'd1) m_en = reg_wdata_i[N-1:0];
    if (wr && reg_addr_i[3:2] == 2'd3) m_swirq = reg_wdata_i[0];
    m_rvalid = reg_req_i;
    if (reg_req_i) m_rdata = rd;
    hist.push_back(irqs_i);
    void'(hist.pop_front());
  endfunction

  function automatic logic [31:0] exp_irq();
    logic [31:0] v;
    v = '0;
    v[16 +: N] = m_pend & m_en;
    v[7] = timer0_irq_i;
    v[3] = m_swirq;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    check("irq_o", irq_o, exp_irq());
    check("rvalid", 32'(reg_rvalid_o), 32'(m_rvalid));
    if (m_rvalid) check("rdata", reg_rdata_o, m_rdata);
  endtask

  task automatic idle();
    reg_req_i = 1'b0; reg_we_i = 1'b0; reg_addr_i = '0; reg_wdata_i = '0;
    irq_ack_i = 1'b0; irq_id_i = '0;
  endtask

  task automatic wr_reg(input logic [3:0] addr, input logic [31:0] data);
    reg_req_i = 1'b1; reg_we_i = 1'b1; reg_addr_i = addr; reg_wdata_i = data;
    tick();
    idle();
  endtask

  task automatic rd_reg(input logic [3:0] addr);
    reg_req_i = 1'b1; reg_we_i = 1'b0; reg_addr_i = addr;
    tick();
    idle();
  endtask

  initial begin
    int cnt, first;
    model_reset();
    @(negedge clk_i);

    // Reset state
    rst_ni = 1'b0;
    tick(); tick();
    check("rst_irq", irq_o, 32'h0);
    check("rst_rvalid", 32'(reg_rvalid_o), 32'h0);
    check("rst_rdata", reg_rdata_o, 32'h0);
    rst_ni = 1'b1;

    // Edge capture on channel 3
    wr_reg(4'h8, 32'h8);
    wr_reg(4'h4, 32'h8);
    irqs_i[3] = 1'b1;
    tick(); check("edge_c1", 32'(irq_o[19]), 32'h0);
    tick(); check("edge_c2", 32'(irq_o[19]), 32'h0);
    irqs_i[3] = 1'b0;
    tick(); check("edge_c3", 32'(irq_o[19]), 32'h1);
    tick(); check("edge_hold", 32'(irq_o[19]), 32'h1);
    irq_ack_i = 1'b1; irq_id_i = 5'd19;
    tick(); idle();
    check("edge_ack", 32'(irq_o[19]), 32'h0);

    // New edge colliding with an ack of the same line
    irqs_i[3] = 1'b1;
    tick(); tick(); tick();
    check("coll_pre", 32'(irq_o[19]), 32'h1);
    irqs_i[3] = 1'b0;
    tick(); tick();
    irqs_i[3] = 1'b1;
    tick(); tick();
    irq_ack_i = 1'b1; irq_id_i = 5'd19;
    tick(); idle();
    check("coll_keep", 32'(irq_o[19]), 32'h1);
    rd_reg(4'h0);
    check("coll_pend", reg_rdata_o, 32'h8);
    irqs_i[3] = 1'b0;
    wr_reg(4'h0, 32'h8);

    // Level mode on channel 5
    wr_reg(4'h4, 32'h28);
    cnt = 0; first = 0;
    for (int t = 1; t <= 16; t++) begin
      if (t == 1) irqs_i[5] = 1'b1;
      if (t == 11) irqs_i[5] = 1'b0;
      if (t == 6) begin irq_ack_i = 1'b1; irq_id_i = 5'd21; end
      tick(); idle();
      if (irq_o[21]) begin
        cnt++;
        if (first == 0) first = t;
      end
    end
    check("level_len", 32'(cnt), 32'd10);
    check("level_lat", 32'(first), 32'd3);

    // Masking of a pending edge on channel 0
    wr_reg(4'h4, 32'h0);
    wr_reg(4'h8, 32'h9);
    irqs_i[0] = 1'b1;
    repeat (3) tick();
    check("mask_irq", irq_o, 32'h0);
    irqs_i[0] = 1'b0;
    rd_reg(4'h0);
    check("mask_pend", reg_rdata_o, 32'h1);
    wr_reg(4'h4, 32'h1);
    check("mask_en", 32'(irq_o[16]), 32'h1);
    wr_reg(4'h0, 32'h1);
    rd_reg(4'h0);
    check("mask_w1c", reg_rdata_o, 32'h0);

    // Timer, software IRQ, ack of a non-fast ID
    wr_reg(4'h4, 32'h0);
    timer0_irq_i = 1'b1;
    #1 check("timer_comb", irq_o, 32'h80);
    wr_reg(4'hC, 32'h1);
    check("swirq", 32'(irq_o[3]), 32'h1);
    irq_ack_i = 1'b1; irq_id_i = 5'd7;
    tick(); idle();
    check("ack7", irq_o, 32'h88);
    timer0_irq_i = 1'b0;
    wr_reg(4'hC, 32'h0);

    // Reset in the middle of activity
    wr_reg(4'h8, 32'h4);
    wr_reg(4'h4, 32'h4);
    irqs_i[2] = 1'b1;
    repeat (3) tick();
    check("rst_pre", 32'(irq_o[18]), 32'h1);
    irqs_i[2] = 1'b0;
    reg_req_i = 1'b1; reg_we_i = 1'b0; reg_addr_i = 4'h0;
    rst_ni = 1'b0;
    tick(); idle();
    rst_ni = 1'b1;
    check("rst_mid_irq", irq_o, 32'h0);
    check("rst_mid_rv", 32'(reg_rvalid_o), 32'h0);
    rd_reg(4'h4);
    check("rst_en", reg_rdata_o, 32'h0);
    rd_reg(4'h8);
    check("rst_mode", reg_rdata_o, 32'h0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      rst_ni       = ($urandom_range(0, 499) != 0);
      irqs_i       = irqs_i ^ N'($urandom & $urandom);
      timer0_irq_i = 1'($urandom);
      irq_ack_i    = ($urandom_range(0, 2) == 0);
      irq_id_i     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(16, 31));
      reg_req_i    = 1'($urandom);
      reg_we_i     = 1'($urandom);
      reg_addr_i   = 4'($urandom);
      reg_wdata_i  = $urandom;
      if (reg_addr_i[3:2] == 2'd2 && $urandom_range(0, 3) != 0) reg_wdata_i = 32'(m_mode);
      tick();
    end
    idle();
    rst_ni = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/core_irq_ctrl.md
Name: core_irq_ctrl

Overview:
- Core-side interrupt controller placed between SoC peripherals and the cv32e40p `irq_i` port.
- Replaces the fixed, combinational IRQ mapping in the core wrapper.
- Accepts up to 16 fast interrupt lines with per-channel synchronisation, level/edge mode, pending latching and enable masking, plus a software-triggerable IRQ.
- Clears edge-pending bits on the core's `irq_ack`/`irq_id` handshake and is configured through a small register port.

Parameters:
- NumIrqs, 16, number of fast IRQ inputs (1..16), mapped to core IRQ bits 16..16+NumIrqs-1.
- SyncStages, 2, flip-flop synchroniser depth on `irqs_i` (0 = bypass, inputs already synchronous).
- ResetEnable, 0, reset value of the ENABLE register (NumIrqs bits).
- ResetMode, 0, reset value of the MODE register (bit=1 selects edge mode).

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  synchronous, active-low reset, sampled on rising `clk_i`.
- irqs_i  in  NumIrqs  fast interrupt sources, may be asynchronous.
- timer0_irq_i  in  1  machine timer IRQ, already synchronous.
- irq_ack_i  in  1  core acknowledges the interrupt in `irq_id_i` this cycle.
- irq_id_i  in  5  ID of the acknowledged interrupt.
- irq_o  out  32  cv32e40p `irq_i` vector.
- reg_req_i  in  1  register access request, always accepted.
- reg_we_i  in  1  1 = write.
- reg_addr_i  in  4  byte offset; bits [1:0] ignored.
- reg_wdata_i  in  32  write data.
- reg_rdata_o  out  32  read data, valid with `reg_rvalid_o`.
- reg_rvalid_o  out  1  response strobe, one cycle after `reg_req_i`.

Behaviour:
- Reset: all synchroniser and edge flops 0; PENDING 0; ENABLE=ResetEnable; MODE=ResetMode; SWIRQ 0; `reg_rvalid_o` 0; `reg_rdata_o` 0; `irq_o` 0.
- Synchronisation: `s[i]` is `irqs_i[i]` after SyncStages flops; `s_d[i]` is `s[i]` delayed by one flop.
- Edge mode (MODE[i]=1):
  - edge[i] = s[i] & ~s_d[i].
  - PENDING[i] sets on the clock after edge[i].
  - Latency from input rise to `irq_o` = SyncStages+1 cycles.
  - PENDING[i] clears on the clock after `irq_ack_i` with `irq_id_i`==16+i, or after a write of 1 to PENDING[i].
  - Set wins: if set and clear occur in the same cycle, the bit stays 1.
  - Pulses shorter than one clock with SyncStages>0 are not guaranteed to be captured.
- Level mode (MODE[i]=0):
  - PENDING[i] mirrors s[i] each cycle; latency SyncStages+1.
  - Ack and W1C have no effect; the source must deassert.
- Mode change: switching MODE[i] clears PENDING[i] on the same clock edge.
- `irq_o` is combinational from flops only:
  - bit 3 = SWIRQ[0]
  - bit 7 = `timer0_irq_i`
  - bit 11 = 0 (reserved for external)
  - bits 16+i = PENDING[i] & ENABLE[i]
  - all other bits 0.
- Disabled-but-pending bits are retained and appear on `irq_o` in the cycle after ENABLE is set.
- Ack with `irq_id_i` outside 16..16+NumIrqs-1 is ignored (including 3, 7, 11). SWIRQ is cleared only by software.
- Register map:
  - 0x0 PENDING: read; write-1-to-clear edge bits.
  - 0x4 ENABLE: RW.
  - 0x8 MODE: RW.
  - 0xC SWIRQ: RW, bit 0 only.
  - Unused bits read 0. Unmapped offsets read 0 and ignore writes.
- Register timing: writes take effect on the clock edge at which the request is sampled. Read data reflects register state before that edge. `reg_rvalid_o` pulses for one cycle, and back-to-back requests are supported.
- Reset mid-operation: all state returns to reset values on the next rising clock with `rst_ni`=0. Any in-flight register response is dropped (`reg_rvalid_o`=0).

Decomposition:
- Package `core_irq_pkg`:
  - Bit-position constants IrqSoftBit=3, IrqTimerBit=7, IrqExtBit=11, IrqFastBase=16.
  - Register offset constants RegPending/RegEnable/RegMode/RegSwirq.
  - Enum for register address decode.
- One sub-module `core_irq_sync`: parametrised N-stage synchroniser, pass-through when SyncStages=0, instantiated NumIrqs wide.

Test Plan:
- Edge capture (SyncStages=2): MODE[3]=1, ENABLE[3]=1, pulse `irqs_i[3]` for 2 cycles -> `irq_o[19]`=1 exactly 3 cycles after the rise and held after the input falls; ack with id 19 -> `irq_o[19]`=0 next cycle.
- Set/clear collision: second edge on channel 3 arrives in the same cycle as the ack of id 19 -> `irq_o[19]` remains 1; PENDING reads 0x8.
- Level mode: MODE[5]=0, ENABLE[5]=1, hold `irqs_i[5]` high for 10 cycles -> `irq_o[21]` high for 10 cycles, delayed by 3; ack id 21 has no effect.
- Masking: ENABLE=0, edge on channel 0 -> `irq_o`=0 and PENDING reads 0x1; write ENABLE=0x1 -> `irq_o[16]`=1 next cycle; W1C PENDING=0x1 -> 0.
- Fixed bits: `timer0_irq_i`=1 -> `irq_o`=0x80 same cycle; write SWIRQ=1 -> `irq_o[3]`=1 next cycle; ack id 7 changes nothing.
- Reset mid-operation: pending channel 2 plus outstanding read, assert `rst_ni`=0 for 1 cycle -> `irq_o`=0, `reg_rvalid_o`=0, and ENABLE/MODE read back reset values.
